// File: rtl/analog_pad_seq_pkg.sv
// rtl/analog_pad_seq_pkg.sv - shared FSM states, register offsets and pad safe-state constants
package analog_pad_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_TARGET   = 5'h04;
  localparam logic [4:0] OFF_DELAY    = 5'h08;
  localparam logic [4:0] OFF_STATUS   = 5'h0C;
  localparam logic [4:0] OFF_IO_STATE = 5'h10;

  localparam logic SAFE_OEB = 1'b1;
  localparam logic SAFE_OUT = 1'b0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/aps_step_timer.sv
// rtl/aps_step_timer.sv - loadable step-delay down-counter that saturates at zero
module aps_step_timer #(
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  output logic             expire
);

  logic [DLY_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  // Fires on the last of the D wait cycles so the next APPLY lands D+1 after the previous one.
  assign expire = (count == DLY_W'(1));

endmodule

// File: rtl/analog_pad_sequencer.sv
// rtl/analog_pad_sequencer.sv - Wishbone-controlled one-pin-at-a-time pad sequencer; irq enabled by ANALOG_PAD_SEQ_IRQ_EN
module analog_pad_sequencer
  import analog_pad_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
  parameter int          NPINS     = 6,
  parameter int          DLY_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [NPINS-1:0] io_out,
  output logic [NPINS-1:0] io_oeb,
  output logic             seq_busy,
  output logic             irq
);

  localparam logic [2:0] LAST_STEP = 3'(NPINS - 1);

  seq_state_t       state;
  logic [2:0]       step;
  logic             done_q;
  logic [NPINS-1:0] target_oeb, target_out, sh_oeb, sh_out;
  logic [DLY_W-1:0] delay_q, sh_dly;
  logic [2:0]       off_w;
  logic             hit, acc, wr;
  logic             ctl_wr, start_req, abort_req, done_clr;
  logic             tmr_load, tmr_expire;
  logic [31:0]      rdata, cur_tgt, tgt_m, dly_m;

  assign hit = wbs_cyc_i && wbs_stb_i &&
               (wbs_adr_i >= BASE_ADDR) && (wbs_adr_i <= BASE_ADDR + 32'h1F);
  // Holding off while ack is high keeps a held strobe from being acked twice in a row.
  assign acc   = hit && !wbs_ack_o;
  assign wr    = acc && wbs_we_i;
  assign off_w = wbs_adr_i[4:2] - BASE_ADDR[4:2];

  assign ctl_wr    = wr && (off_w == OFF_CTRL[4:2]) && wbs_sel_i[0];
  assign abort_req = ctl_wr && wbs_dat_i[1];
  assign start_req = ctl_wr && wbs_dat_i[0] && !wbs_dat_i[1];
  assign done_clr  = wr && (off_w == OFF_STATUS[4:2]) && wbs_sel_i[0] && wbs_dat_i[1];

  always_comb begin
    cur_tgt = '0;
    cur_tgt[NPINS-1:0] = target_oeb;
    cur_tgt[8 +: NPINS] = target_out;
    tgt_m = merge_bytes(cur_tgt, wbs_dat_i, wbs_sel_i);
    dly_m = merge_bytes(32'(delay_q), wbs_dat_i, wbs_sel_i);
  end

  always_comb begin
    rdata = '0;
    case (off_w)
      OFF_TARGET[4:2]: rdata = cur_tgt;
      OFF_DELAY[4:2]:  rdata[DLY_W-1:0] = delay_q;
      OFF_STATUS[4:2]: begin
        rdata[0]    = seq_busy;
        rdata[1]    = done_q;
        rdata[10:8] = step;
      end
      OFF_IO_STATE[4:2]: begin
        rdata[NPINS-1:0]  = io_oeb;
        rdata[8 +: NPINS] = io_out;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      target_oeb <= '0;
      target_out <= '0;
      delay_q    <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rdata : '0;
      if (wr && off_w == OFF_TARGET[4:2]) begin
        target_oeb <= tgt_m[NPINS-1:0];
        target_out <= tgt_m[8 +: NPINS];
      end
      if (wr && off_w == OFF_DELAY[4:2])
        delay_q <= dly_m[DLY_W-1:0];
    end
  end

  assign tmr_load = (state == S_APPLY) && (sh_dly != '0) && !abort_req;

  aps_step_timer #(.DLY_W(DLY_W)) u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clear    (abort_req),
    .load     (tmr_load),
    .load_val (sh_dly),
    .expire   (tmr_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      step     <= '0;
      done_q   <= 1'b0;
      seq_busy <= 1'b0;
      sh_oeb   <= '0;
      sh_out   <= '0;
      sh_dly   <= '0;
      io_oeb   <= {NPINS{SAFE_OEB}};
      io_out   <= {NPINS{SAFE_OUT}};
    end else begin
      if (done_clr)
        done_q <= 1'b0;
      if (abort_req) begin
        state    <= S_IDLE;
        step     <= '0;
        done_q   <= 1'b0;
        seq_busy <= 1'b0;
        io_oeb   <= {NPINS{SAFE_OEB}};
        io_out   <= {NPINS{SAFE_OUT}};
      end else begin
        case (state)
          S_IDLE: if (start_req) begin
            sh_oeb <= target_oeb;
            sh_out <= target_out;
            sh_dly <= delay_q;
            step   <= '0;
            done_q <= 1'b0;
            state  <= S_APPLY;
          end
          S_APPLY: begin
            io_oeb[step] <= sh_oeb[step];
            io_out[step] <= sh_out[step];
            seq_busy     <= 1'b1;
            if (sh_dly != '0)
              state <= S_WAIT;
            else if (step == LAST_STEP)
              state <= S_DONE;
            else
              step <= step + 3'd1;
          end
          S_WAIT: if (tmr_expire) begin
            if (step == LAST_STEP)
              state <= S_DONE;
            else begin
              step  <= step + 3'd1;
              state <= S_APPLY;
            end
          end
          S_DONE: begin
            done_q   <= 1'b1;
            seq_busy <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef ANALOG_PAD_SEQ_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      irq <= 1'b0;
    else
      irq <= (state == S_DONE) && !abort_req;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_analog_pad_sequencer.sv
// tb/tb_analog_pad_sequencer.sv - self-checking bench with a cycle-level pad reference model
module tb_analog_pad_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0100;
`ifdef ANALOG_PAD_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [5:0]  pad_out, pad_oeb;
  logic        busy, irq;

  int tests = 0;
  int fails = 0;
  logic [5:0] m_oeb, m_out;

  analog_pad_sequencer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_out    (pad_out),
    .io_oeb    (pad_oeb),
    .seq_busy  (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic bus(input logic [31:0] a, input bit w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    bit got = 1'b0;
    r = '0;
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin got = 1'b1; r = rdat; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL bus_timeout adr=%h ack=0 required=1", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 1'b1, d, 4'hF, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bus(a, 1'b0, 32'h0, 4'hF, r);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({pad_oeb, pad_out, ack, busy, irq} !== {6'h3F, 6'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_outputs oeb=%h out=%h ack=%b busy=%b irq=%b required oeb=3f out=00 ack/busy/irq=0",
               pad_oeb, pad_out, ack, busy, irq);
    end
    rst = 1'b0;
    rd(BASE + 32'h0C, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL reset_status got=%h required=0", r); end
    rd(BASE + 32'h04, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL reset_target got=%h required=0", r); end
    rd(BASE + 32'h10, r);
    tests++;
    if (r !== 32'h3F) begin fails++; $display("FAIL reset_io_state got=%h required=3f", r); end
    m_oeb = 6'h3F; m_out = 6'h00;
  endtask

  task automatic test_window;
    logic [31:0] r;
    int acks, prev, b2b;
    rd(BASE + 32'h18, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL unmapped_read got=%h required=0", r); end
    acks = 0;
    @(negedge clk);
    adr = BASE + 32'h40; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    repeat (10) begin @(negedge clk); if (ack === 1'b1) acks++; end
    cyc = 1'b0; stb = 1'b0;
    tests++;
    if (acks != 0) begin fails++; $display("FAIL out_of_window acks=%0d required=0", acks); end
    acks = 0; prev = 0; b2b = 0;
    @(negedge clk);
    adr = BASE + 32'h04; cyc = 1'b1; stb = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ack === 1'b1) begin acks++; if (prev) b2b++; prev = 1; end else prev = 0;
    end
    cyc = 1'b0; stb = 1'b0;
    tests++;
    if (acks == 0 || b2b != 0) begin
      fails++; $display("FAIL held_strobe acks=%0d back_to_back=%0d required acks>0 back_to_back=0", acks, b2b);
    end
  endtask

  task automatic test_sel;
    logic [31:0] r;
    wr(BASE + 32'h04, 32'h0);
    bus(BASE + 32'h04, 1'b1, 32'h0000_3F3F, 4'b0001, r);
    rd(BASE + 32'h04, r);
    tests++;
    if (r !== 32'h0000_003F) begin fails++; $display("FAIL sel_byte0 got=%h required=0000003f", r); end
    bus(BASE + 32'h04, 1'b1, 32'hFFFF_2AFF, 4'b0010, r);
    rd(BASE + 32'h04, r);
    tests++;
    if (r !== 32'h0000_2A3F) begin fails++; $display("FAIL sel_byte1 got=%h required=00002a3f", r); end
  endtask

  task automatic run_seq(input string name, input logic [31:0] tgt, input int d,
                         input int rewrite_k, input int abort_k);
    logic [31:0] r;
    logic [5:0]  s_oeb, s_out, e_oeb, e_out;
    bit          e_busy, e_irq, aborted;
    int          span;
    aborted = 1'b0;
    wr(BASE + 32'h04, tgt);
    wr(BASE + 32'h08, 32'(d));
    wr(BASE + 32'h00, 32'h1);
    s_oeb = tgt[5:0]; s_out = tgt[13:8];
    span  = 6 * (d + 1);
    for (int k = 0; k <= span + 1; k++) begin
      @(negedge clk);
      if (k == rewrite_k + 1 || k == abort_k + 1) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
      if (abort_k >= 0 && k == abort_k + 1) begin
        tests++;
        if ({pad_oeb, pad_out, busy, irq} !== {6'h3F, 6'h00, 2'b00}) begin
          fails++;
          $display("FAIL %s abort_safe k=%0d oeb=%h out=%h busy=%b irq=%b required oeb=3f out=00 busy=0 irq=0",
                   name, k, pad_oeb, pad_out, busy, irq);
        end
        m_oeb = 6'h3F; m_out = 6'h00; aborted = 1'b1;
        break;
      end
      e_oeb = m_oeb; e_out = m_out;
      for (int j = 0; j < 6; j++)
        if (j * (d + 1) <= k) begin e_oeb[j] = s_oeb[j]; e_out[j] = s_out[j]; end
      e_busy = (k < span);
      e_irq  = IRQ_EN && (k == span);
      tests++;
      if ({pad_oeb, pad_out, busy, irq} !== {e_oeb, e_out, e_busy, e_irq}) begin
        fails++;
        $display("FAIL %s k=%0d oeb=%h out=%h busy=%b irq=%b required oeb=%h out=%h busy=%b irq=%b",
                 name, k, pad_oeb, pad_out, busy, irq, e_oeb, e_out, e_busy, e_irq);
      end
      if (k == rewrite_k) begin
        adr = BASE + 32'h04; wdat = ~tgt; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      end
      if (k == abort_k) begin
        adr = BASE; wdat = 32'h3; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      end
    end
    if (!aborted) begin m_oeb = s_oeb; m_out = s_out; end
    rd(BASE + 32'h0C, r);
    tests++;
    if (r[1:0] !== (aborted ? 2'b00 : 2'b10)) begin
      fails++; $display("FAIL %s status_done_busy got=%b required=%b", name, r[1:0], aborted ? 2'b00 : 2'b10);
    end
    rd(BASE + 32'h10, r);
    tests++;
    if (r !== {18'h0, m_out, 2'b00, m_oeb}) begin
      fails++; $display("FAIL %s io_state got=%h required=%h", name, r, {18'h0, m_out, 2'b00, m_oeb});
    end
  endtask

  task automatic test_done_clear;
    logic [31:0] r;
    wr(BASE + 32'h0C, 32'h2);
    rd(BASE + 32'h0C, r);
    tests++;
    if (r[1] !== 1'b0) begin fails++; $display("FAIL done_clear got=%b required=0", r[1]); end
  endtask

  task automatic test_reset_mid;
    wr(BASE + 32'h04, 32'h0000_3F00);
    wr(BASE + 32'h08, 32'd5);
    wr(BASE + 32'h00, 32'h1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    adr = BASE + 32'h04; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    tests++;
    if ({pad_oeb, pad_out, ack, busy} !== {6'h3F, 6'h00, 2'b00}) begin
      fails++;
      $display("FAIL reset_mid oeb=%h out=%h ack=%b busy=%b required oeb=3f out=00 ack=0 busy=0",
               pad_oeb, pad_out, ack, busy);
    end
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    m_oeb = 6'h3F; m_out = 6'h00;
  endtask

  initial begin
    test_reset;
    test_window;
    test_sel;
    run_seq("delay3", 32'h0000_2A15, 3, -1, -1);
    test_done_clear;
    run_seq("delay0", 32'h0000_152A, 0, -1, -1);
    run_seq("rewrite", 32'h0000_0C33, 3, 2, -1);
    run_seq("abort", 32'h0000_3F00, 3, -1, 13);
    for (int n = 0; n < 4; n++)
      run_seq("random", $urandom, int'($urandom_range(0, 4)), -1, -1);
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
